// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one spi_mem transfer engine between the fetch and data ports
module spi_mem_arbiter #(
  parameter int FAIR       = 0,
  parameter int TIMEOUT    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req_i,
  input  logic [15:0] f_addr_i,
  output logic        f_done_o,
  output logic [15:0] f_instr_o,
  input  logic        d_req_i,
  input  logic        d_rwb_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_done_o,
  output logic [15:0] d_rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_start_o,
  output logic        mem_rwb_o,
  output logic        mem_sel_dest_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  input  logic        mem_csb_i,
  input  logic [15:0] mem_inM_i,
  input  logic [15:0] mem_instr_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic last_grant, grant_d, tmo, tmo_n;
  assign cnt_inc = cnt + 1'b1;
  assign grant_d = d_req_i && (!f_req_i || FAIR == 0 || !last_grant);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tmo_n   = tmo;
    case (state)
      IDLE: state_n = (f_req_i || d_req_i) ? ISSUE : IDLE;
      ISSUE: begin
        state_n = WAIT_BUSY;
        cnt_n   = '0;
        tmo_n   = 1'b0;
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (state == WAIT_BUSY && !mem_csb_i) begin
          state_n = WAIT_DONE;
          cnt_n   = '0;
        end else if (state == WAIT_DONE && mem_csb_i) begin
          state_n = COMPLETE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_n = COMPLETE;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      COMPLETE: begin
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: begin
        state_n = (cnt == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
        cnt_n   = (cnt == CW'(GAP_CYCLES - 1)) ? '0 : cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      tmo            <= 1'b0;
      last_grant     <= 1'b0;
      busy_o         <= 1'b0;
      mem_start_o    <= 1'b0;
      f_done_o       <= 1'b0;
      d_done_o       <= 1'b0;
      err_o          <= 1'b0;
      f_instr_o      <= '0;
      d_rdata_o      <= '0;
      mem_rwb_o      <= 1'b0;
      mem_sel_dest_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tmo         <= tmo_n;
      busy_o      <= state_n != IDLE;
      mem_start_o <= state_n == ISSUE;
      f_done_o    <= state == COMPLETE && !mem_sel_dest_o;
      d_done_o    <= state == COMPLETE && mem_sel_dest_o;
      err_o       <= state == COMPLETE && tmo;
      if (state == IDLE && state_n == ISSUE) begin
        last_grant     <= grant_d;
        mem_sel_dest_o <= grant_d;
        mem_rwb_o      <= grant_d ? d_rwb_i : 1'b1;
        mem_addr_o     <= grant_d ? d_addr_i : f_addr_i;
        mem_data_o     <= grant_d ? d_wdata_i : '0;
      end
      // a timed-out transfer leaves the read-data registers untouched
      if (state == COMPLETE && !tmo) begin
        if (!mem_sel_dest_o) f_instr_o <= mem_instr_i;
        else if (mem_rwb_o) d_rdata_o <= mem_inM_i;
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: table vectors plus scoreboard checking of spi_mem_arbiter against a simple spi_mem model
module tb_spi_mem_arbiter;
  typedef struct {
    logic        dp;
    logic        rwb;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    logic        err;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stuck = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  vec_t sbq[$];
  vec_t tbl[8];
  logic a_freq = 0, a_dreq = 0, a_drwb = 0;
  logic [15:0] a_faddr = 0, a_daddr = 0, a_dwdata = 0;
  logic a_fd, a_dd, a_err, a_busy, a_start, a_rwb, a_sel, a_csb, a_start_q;
  logic [15:0] a_instr, a_rdata, a_addr, a_mdata, a_inm, a_imem;
  logic [3:0] a_cnt;
  logic b_freq = 0, b_dreq = 0, b_drwb = 0;
  logic [15:0] b_faddr = 0, b_daddr = 0, b_dwdata = 0;
  logic b_fd, b_dd, b_err, b_busy, b_start, b_rwb, b_sel, b_csb;
  logic [15:0] b_instr, b_rdata, b_addr, b_mdata, b_inm, b_imem;
  logic [3:0] b_cnt;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.FAIR(0), .TIMEOUT(63), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
    .f_req_i(a_freq), .f_addr_i(a_faddr), .f_done_o(a_fd), .f_instr_o(a_instr),
    .d_req_i(a_dreq), .d_rwb_i(a_drwb), .d_addr_i(a_daddr), .d_wdata_i(a_dwdata),
    .d_done_o(a_dd), .d_rdata_o(a_rdata), .err_o(a_err), .busy_o(a_busy),
    .mem_start_o(a_start), .mem_rwb_o(a_rwb), .mem_sel_dest_o(a_sel),
    .mem_addr_o(a_addr), .mem_data_o(a_mdata), .mem_csb_i(a_csb),
    .mem_inM_i(a_inm), .mem_instr_i(a_imem));

  spi_mem_arbiter #(.FAIR(1), .TIMEOUT(63), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset),
    .f_req_i(b_freq), .f_addr_i(b_faddr), .f_done_o(b_fd), .f_instr_o(b_instr),
    .d_req_i(b_dreq), .d_rwb_i(b_drwb), .d_addr_i(b_daddr), .d_wdata_i(b_dwdata),
    .d_done_o(b_dd), .d_rdata_o(b_rdata), .err_o(b_err), .busy_o(b_busy),
    .mem_start_o(b_start), .mem_rwb_o(b_rwb), .mem_sel_dest_o(b_sel),
    .mem_addr_o(b_addr), .mem_data_o(b_mdata), .mem_csb_i(b_csb),
    .mem_inM_i(b_inm), .mem_instr_i(b_imem));

  // spi_mem stand-in: csb low for cycles 3..6 after start; data is a fixed function of the address
  always @(posedge clk or posedge reset)
    if (reset) a_cnt <= 4'd0;
    else if (a_start && !stuck) a_cnt <= 4'd1;
    else if (a_cnt != 4'd0) a_cnt <= (a_cnt == 4'd8) ? 4'd0 : a_cnt + 4'd1;
  always @(posedge clk or posedge reset)
    if (reset) b_cnt <= 4'd0;
    else if (b_start) b_cnt <= 4'd1;
    else if (b_cnt != 4'd0) b_cnt <= (b_cnt == 4'd8) ? 4'd0 : b_cnt + 4'd1;
  assign a_csb  = stuck || !(a_cnt >= 4'd3 && a_cnt <= 4'd6);
  assign b_csb  = !(b_cnt >= 4'd3 && b_cnt <= 4'd6);
  assign a_inm  = a_addr ^ 16'h5A5A;
  assign a_imem = a_addr ^ 16'hEC00;
  assign b_inm  = b_addr ^ 16'h5A5A;
  assign b_imem = b_addr ^ 16'hEC00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    vec_t t;
    if (!reset) begin
      if (a_start) begin
        chk("start_one_cycle", a_start_q, 0);
        if (sbq.size() == 0) chk("start_expected", sbq.size(), 1);
        else begin
          chk("start_sel", a_sel, sbq[0].dp);
          chk("start_rwb", a_rwb, sbq[0].dp ? sbq[0].rwb : 1'b1);
          chk("start_addr", a_addr, sbq[0].addr);
          chk("start_wdata", a_mdata, sbq[0].dp ? sbq[0].wdata : 16'h0);
        end
      end
      if (a_fd || a_dd) begin
        if (sbq.size() == 0) chk("done_expected", sbq.size(), 1);
        else begin
          t = sbq.pop_front();
          chk("done_port", {a_fd, a_dd}, t.dp ? 2'b01 : 2'b10);
          chk("done_data", t.dp ? a_rdata : a_instr, t.exp);
          chk("done_err", a_err, t.err);
        end
      end
    end
    a_start_q = a_start;
  end

  task automatic rst_chk(input string nm);
    chk({nm, "_a_ctrl"}, {a_fd, a_dd, a_err, a_busy, a_start, a_rwb, a_sel}, 0);
    chk({nm, "_a_addr_data"}, {a_addr, a_mdata}, 0);
    chk({nm, "_a_rd"}, {a_instr, a_rdata}, 0);
    chk({nm, "_b_ctrl"}, {b_fd, b_dd, b_err, b_busy, b_start, b_rwb, b_sel}, 0);
    chk({nm, "_b_addr_data"}, {b_addr, b_mdata}, 0);
  endtask

  task automatic issue(input vec_t v);
    sbq.push_back(v);
    if (v.dp) begin
      a_dreq = 1; a_drwb = v.rwb; a_daddr = v.addr; a_dwdata = v.wdata;
    end else begin
      a_freq = 1; a_faddr = v.addr;
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!a_start && n < 100);
    chk("start_seen", a_start, 1);
  endtask

  task automatic wait_done(input logic dp, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(dp ? a_dd : a_fd) && n < 300);
    chk("done_seen", dp ? a_dd : a_fd, 1);
    if (dp) a_dreq = 0; else a_freq = 0;
  endtask

  task automatic gap_chk();
    chk("busy_at_done", a_busy, 1);
    @(negedge clk);
    chk("done_one_cycle", {a_fd, a_dd, a_err}, 0);
    chk("gap_busy", a_busy, 1);
    @(negedge clk);
    chk("idle_after_gap", a_busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    issue(v);
    wait_start(n);
    chk("start_latency", n, 1);
    wait_done(v.dp, n);
    gap_chk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] order;
    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hEC10, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h1234, 16'hBEEF, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h1234, 16'h0000, 16'h486E, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0ABC, 16'h1111, 16'h486E, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h13FF, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'h8001, 16'h0000, 16'h6C01, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 16'hA5A5, 16'h0000, 16'hFFFF, 1'b0};
    repeat (3) @(negedge clk);
    rst_chk("reset");
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    stuck = 1;
    issue('{1'b1, 1'b1, 16'h0300, 16'h0000, 16'hFFFF, 1'b1});
    wait_start(n);
    wait_done(1'b1, n);
    chk("timeout_cycles", n, 65);
    gap_chk();
    stuck = 0;
    issue('{1'b1, 1'b1, 16'h2222, 16'h0000, 16'h7878, 1'b0});
    issue('{1'b0, 1'b1, 16'h0042, 16'h0000, 16'hEC42, 1'b0});
    wait_start(n);
    wait_done(1'b1, n);
    n = 0;
    do begin @(negedge clk); n++; end while (!a_start && n < 20);
    chk("contention_gap", n, 3);
    wait_done(1'b0, n);
    gap_chk();
    issue('{1'b1, 1'b1, 16'h4444, 16'h0000, 16'h1E1E, 1'b0});
    wait_start(n);
    n = 0;
    while (a_csb && n < 20) begin @(negedge clk); n++; end
    chk("reach_wait_done", a_csb, 0);
    a_daddr = 16'hFFFF; a_drwb = 0; a_dwdata = 16'h9999;
    repeat (3) begin
      @(negedge clk);
      chk("addr_stable", a_addr, 16'h4444);
      chk("rwb_stable", a_rwb, 1);
    end
    wait_done(1'b1, n);
    gap_chk();
    issue('{1'b0, 1'b1, 16'h0777, 16'h0000, 16'h0000, 1'b0});
    wait_start(n);
    n = 0;
    while (a_csb && n < 20) begin @(negedge clk); n++; end
    chk("reset_reach_wait_done", a_csb, 0);
    @(negedge clk);
    #2 reset = 1;
    #1 rst_chk("async_reset");
    sbq.delete();
    a_freq = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    run_vec('{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hEC10, 1'b0});
    order = 4'b0101;
    b_faddr = 16'h0100; b_daddr = 16'h0200; b_drwb = 1; b_freq = 1; b_dreq = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!b_start && n < 100);
      chk("fair_start_seen", b_start, 1);
      chk("fair_grant", b_sel, order[k]);
      n = 0;
      do begin @(negedge clk); n++; end while (!(b_fd || b_dd) && n < 100);
      chk("fair_done", {b_fd, b_dd}, order[k] ? 2'b01 : 2'b10);
      chk("fair_data", order[k] ? b_rdata : b_instr, order[k] ? 16'h585A : 16'hED00);
    end
    b_freq = 0; b_dreq = 0;
    repeat (4) @(negedge clk);
    chk("fair_idle", b_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single SPI RAM transfer engine (spi_mem) between the CPU instruction-fetch port and the CPU data (load/store) port.
- Accepts one request at a time, drives spi_mem's start/rwb/selDest/address/data, and detects completion from the chip-select edge.
- Returns read data and a one-cycle done pulse to the granted requester, and enforces spi_mem's recovery gap between transfers.

Parameters:
- FAIR, 0, 0 = data port always wins; 1 = alternate grants when both ports are pending.
- TIMEOUT, 63, max cycles spent in either wait state before aborting; counter width is clog2(TIMEOUT+1).
- GAP_CYCLES, 2, idle cycles after completion before the next start; minimum legal value is 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- f_req_i  in  1  fetch request; held until f_done_o.
- f_addr_i  in  16  fetch address.
- f_done_o  out  1  one-cycle fetch completion pulse.
- f_instr_o  out  16  fetched instruction; valid while f_done_o=1, held afterwards.
- d_req_i  in  1  data request; held until d_done_o.
- d_rwb_i  in  1  1 = read, 0 = write.
- d_addr_i  in  16  data address.
- d_wdata_i  in  16  write data.
- d_done_o  out  1  one-cycle data completion pulse.
- d_rdata_o  out  16  read data; valid while d_done_o=1, held afterwards.
- err_o  out  1  one-cycle timeout pulse, coincident with the corresponding done pulse.
- busy_o  out  1  1 in every state except IDLE.
- mem_start_o  out  1  to spi_mem start_i.
- mem_rwb_o  out  1  to spi_mem rwb_i.
- mem_sel_dest_o  out  1  to spi_mem selDest_i; 1 = data, 0 = fetch.
- mem_addr_o  out  16  to spi_mem address_i.
- mem_data_o  out  16  to spi_mem data_i.
- mem_csb_i  in  1  from spi_mem csb_o.
- mem_inM_i  in  16  from spi_mem inM_o.
- mem_instr_i  in  16  from spi_mem instruction_o.

Behaviour:
- Reset values: state IDLE, every output 0, counters 0, last_grant = fetch.
- All outputs are registered. Requester inputs are sampled only in IDLE.
- States and transitions:
  - IDLE: if any request is pending, pick a winner, latch addr/rwb/wdata/selDest into the mem_* registers, go to ISSUE.
    - FAIR=0: data wins.
    - FAIR=1: when both are pending, grant the port not in last_grant, then update last_grant.
    - Fetch grant forces rwb=1, sel_dest=0, data=0.
  - ISSUE: mem_start_o=1 for exactly this one cycle, then WAIT_BUSY.
  - WAIT_BUSY: wait for mem_csb_i==0, then WAIT_DONE. Timeout counter runs.
  - WAIT_DONE: wait for mem_csb_i==1, then COMPLETE. Timeout counter is cleared on entry.
  - COMPLETE: pulse the granted port's done for 1 cycle.
    - Data read: d_rdata_o <= mem_inM_i.
    - Fetch: f_instr_o <= mem_instr_i.
    - Write: d_rdata_o unchanged.
    - Then go to GAP.
  - GAP: count GAP_CYCLES cycles, then IDLE.
- Latency: request seen in IDLE cycle N gives mem_start_o at N+1; done arrives 2 cycles after the csb rising edge is sampled.
- mem_addr_o, mem_data_o, mem_rwb_o and mem_sel_dest_o stay stable from ISSUE through GAP. Requester input changes during this window are ignored.
- Timeout: the counter reaching TIMEOUT in either wait state forces COMPLETE.
  - err_o=1 together with the done pulse.
  - Read data registers keep their previous value.
- Simultaneous events:
  - A request arriving during busy is held off and served in the first IDLE cycle.
  - Both requests asserted with FAIR=0: the fetch port waits until the data port has been served.
- A requester deasserting req before done is illegal; the transfer still completes and done still pulses.
- Reset mid-transfer: immediate return to IDLE and all outputs 0, including mem_start_o. spi_mem is reset by the same system reset (as resetb = ~reset).

Test Plan:
- Fetch read: f_req, addr 0x0010; spi_mem model returns 0xEC10 -> mem_start_o 1 cycle with rwb=1, sel=0, addr 0x0010; f_done 1 cycle with f_instr_o=0xEC10; ≥2 GAP cycles follow.
- Data write: d_req, rwb=0, addr 0x1234, wdata 0xBEEF -> mem_data_o=0xBEEF, sel=1, rwb=0; d_done pulse; d_rdata_o unchanged.
- Contention, FAIR=0: both req in the same cycle -> data served first, fetch starts exactly GAP_CYCLES+1 cycles after d_done. Repeat with FAIR=1 for 4 back-to-back transactions -> grants alternate D,F,D,F.
- Timeout: mem_csb_i stuck at 1 -> after 63 WAIT_BUSY cycles, d_done and err_o pulse together, busy_o returns to 0.
- Reset mid-WAIT_DONE -> all outputs 0 asynchronously; a new fetch after release completes normally.
- Stability: toggle d_addr_i during WAIT_DONE -> mem_addr_o unchanged.
